// File: rtl/edge_detection_pkg.sv
// Shared constants for the edge-detection path: subpixel depth, gradient width,
// neighbour slice positions within the packed 3x3 matrix, and saturation limit.
package edge_detection_pkg;

  localparam int unsigned SUBPIXEL_DEPTH = 8;
  localparam int unsigned GRADIENT_BITS  = SUBPIXEL_DEPTH + 3;
  localparam int unsigned SATURATION_MAX = (1 << SUBPIXEL_DEPTH) - 1;

  // Slice index of each neighbour; tl occupies the MSBs, br the LSBs.
  typedef enum int unsigned {
    NB_BR = 0,
    NB_B  = 1,
    NB_BL = 2,
    NB_MR = 3,
    NB_ML = 4,
    NB_TR = 5,
    NB_T  = 6,
    NB_TL = 7
  } neighbour_e;

  function automatic int unsigned slice_lsb(input neighbour_e nb, input int unsigned depth);
    return int'(nb) * depth;
  endfunction

endpackage

// File: rtl/sobel_gradient.sv
// Combinational Sobel kernels: signed Gx/Gy from the eight neighbours of a
// 3x3 grayscale matrix (centre pixel is not used by either kernel).
module sobel_gradient
  import edge_detection_pkg::*;
#(
  parameter int unsigned P_SUBPIXEL_DEPTH = SUBPIXEL_DEPTH,
  localparam int unsigned GW = P_SUBPIXEL_DEPTH + 3
) (
  input  logic        [8*P_SUBPIXEL_DEPTH-1:0] pixel_matrix,
  output logic signed [GW-1:0]                 gx,
  output logic signed [GW-1:0]                 gy
);

  logic signed [GW-1:0] tl, t, tr, ml, mr, bl, b, br;

  assign tl = GW'(pixel_matrix[slice_lsb(NB_TL, P_SUBPIXEL_DEPTH) +: P_SUBPIXEL_DEPTH]);
  assign t  = GW'(pixel_matrix[slice_lsb(NB_T,  P_SUBPIXEL_DEPTH) +: P_SUBPIXEL_DEPTH]);
  assign tr = GW'(pixel_matrix[slice_lsb(NB_TR, P_SUBPIXEL_DEPTH) +: P_SUBPIXEL_DEPTH]);
  assign ml = GW'(pixel_matrix[slice_lsb(NB_ML, P_SUBPIXEL_DEPTH) +: P_SUBPIXEL_DEPTH]);
  assign mr = GW'(pixel_matrix[slice_lsb(NB_MR, P_SUBPIXEL_DEPTH) +: P_SUBPIXEL_DEPTH]);
  assign bl = GW'(pixel_matrix[slice_lsb(NB_BL, P_SUBPIXEL_DEPTH) +: P_SUBPIXEL_DEPTH]);
  assign b  = GW'(pixel_matrix[slice_lsb(NB_B,  P_SUBPIXEL_DEPTH) +: P_SUBPIXEL_DEPTH]);
  assign br = GW'(pixel_matrix[slice_lsb(NB_BR, P_SUBPIXEL_DEPTH) +: P_SUBPIXEL_DEPTH]);

  // Three guard bits hold +/-4*max exactly, so no intermediate can overflow.
  assign gx = (tr + (mr <<< 1) + br) - (tl + (ml <<< 1) + bl);
  assign gy = (bl + (b  <<< 1) + br) - (tl + (t  <<< 1) + tr);

endmodule

// File: rtl/sobel_edge_filter.sv
// Three-stage Sobel edge filter: gradients, L1 magnitude, saturate/register.
// Build option: SOBEL_BINARY_THRESHOLD_EN turns the output into a binary edge map.
module sobel_edge_filter
  import edge_detection_pkg::*;
#(
  parameter int unsigned P_FRAME_COLUMNS     = 640,
  parameter int unsigned P_FRAME_ROWS        = 480,
  parameter int unsigned P_SUBPIXEL_DEPTH    = SUBPIXEL_DEPTH,
  parameter int unsigned P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  parameter int unsigned P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS),
  parameter int unsigned P_PIXEL_MATRIX_BITS = 8 * P_SUBPIXEL_DEPTH
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic [P_PIXEL_MATRIX_BITS-1:0] I_PIXEL_MATRIX,
  input  logic [P_FRAME_COLUMN_BITS-1:0] I_PIXEL_COLUMN,
  input  logic [P_FRAME_ROW_BITS-1:0]    I_PIXEL_ROW,
  input  logic                           I_PIXEL_MATRIX_READY,
  input  logic [P_SUBPIXEL_DEPTH-1:0]    I_THRESHOLD,
  output logic [P_SUBPIXEL_DEPTH-1:0]    O_EDGE_PIXEL,
  output logic [P_FRAME_COLUMN_BITS-1:0] O_EDGE_COLUMN,
  output logic [P_FRAME_ROW_BITS-1:0]    O_EDGE_ROW,
  output logic                           O_EDGE_VALID,
  output logic                           O_FRAME_DONE
);

  localparam int unsigned GW = P_SUBPIXEL_DEPTH + 3;
  localparam logic [P_FRAME_COLUMN_BITS-1:0] LAST_COLUMN = P_FRAME_COLUMN_BITS'(P_FRAME_COLUMNS - 2);
  localparam logic [P_FRAME_ROW_BITS-1:0]    LAST_ROW    = P_FRAME_ROW_BITS'(P_FRAME_ROWS - 2);

  logic signed [GW-1:0]            gx_comb, gy_comb;
  logic signed [GW-1:0]            gx_s1, gy_s1;
  logic                            valid_s1, valid_s2;
  logic [P_FRAME_COLUMN_BITS-1:0]  column_s1, column_s2;
  logic [P_FRAME_ROW_BITS-1:0]     row_s1, row_s2;
  logic [GW-1:0]                   abs_gx, abs_gy, magnitude_s2;
  logic [P_SUBPIXEL_DEPTH-1:0]     saturated, pixel_next;

  sobel_gradient #(
    .P_SUBPIXEL_DEPTH(P_SUBPIXEL_DEPTH)
  ) u_gradient (
    .pixel_matrix(I_PIXEL_MATRIX),
    .gx          (gx_comb),
    .gy          (gy_comb)
  );

  always_comb begin
    abs_gx = gx_s1[GW-1] ? -gx_s1 : gx_s1;
    abs_gy = gy_s1[GW-1] ? -gy_s1 : gy_s1;
  end

  always_comb begin
    saturated = magnitude_s2[P_SUBPIXEL_DEPTH-1:0];
    if (|magnitude_s2[GW-1:P_SUBPIXEL_DEPTH]) saturated = '1;
  end

`ifdef SOBEL_BINARY_THRESHOLD_EN
  always_comb begin
    pixel_next = '0;
    if (saturated >= I_THRESHOLD) pixel_next = '1;
  end
`else
  logic unused_threshold;
  assign unused_threshold = ^I_THRESHOLD;
  always_comb begin
    pixel_next = saturated;
  end
`endif

  // Output data only loads on a valid entry so it stays zero after reset
  // until the first real result arrives.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      valid_s1      <= 1'b0;
      valid_s2      <= 1'b0;
      O_EDGE_VALID  <= 1'b0;
      O_FRAME_DONE  <= 1'b0;
      O_EDGE_PIXEL  <= '0;
      O_EDGE_COLUMN <= '0;
      O_EDGE_ROW    <= '0;
    end else begin
      valid_s1     <= I_PIXEL_MATRIX_READY;
      gx_s1        <= gx_comb;
      gy_s1        <= gy_comb;
      column_s1    <= I_PIXEL_COLUMN + 1'b1;
      row_s1       <= I_PIXEL_ROW + 1'b1;

      valid_s2     <= valid_s1;
      magnitude_s2 <= abs_gx + abs_gy;
      column_s2    <= column_s1;
      row_s2       <= row_s1;

      O_EDGE_VALID <= valid_s2;
      O_FRAME_DONE <= valid_s2 && (column_s2 == LAST_COLUMN) && (row_s2 == LAST_ROW);
      if (valid_s2) begin
        O_EDGE_PIXEL  <= pixel_next;
        O_EDGE_COLUMN <= column_s2;
        O_EDGE_ROW    <= row_s2;
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Self-checking bench for sobel_edge_filter: directed cases plus randomized
// traffic compared against a queue-based reference model.
module tb_sobel_edge_filter;

  localparam int COLS = 640;
  localparam int ROWS = 480;

  logic        I_CLK = 1'b0;
  logic        I_RESET;
  logic [63:0] I_PIXEL_MATRIX;
  logic [9:0]  I_PIXEL_COLUMN;
  logic [8:0]  I_PIXEL_ROW;
  logic        I_PIXEL_MATRIX_READY;
  logic [7:0]  I_THRESHOLD;
  logic [7:0]  O_EDGE_PIXEL;
  logic [9:0]  O_EDGE_COLUMN;
  logic [8:0]  O_EDGE_ROW;
  logic        O_EDGE_VALID;
  logic        O_FRAME_DONE;

  sobel_edge_filter #(
    .P_FRAME_COLUMNS (COLS),
    .P_FRAME_ROWS    (ROWS),
    .P_SUBPIXEL_DEPTH(8)
  ) dut (
    .I_CLK               (I_CLK),
    .I_RESET             (I_RESET),
    .I_PIXEL_MATRIX      (I_PIXEL_MATRIX),
    .I_PIXEL_COLUMN      (I_PIXEL_COLUMN),
    .I_PIXEL_ROW         (I_PIXEL_ROW),
    .I_PIXEL_MATRIX_READY(I_PIXEL_MATRIX_READY),
    .I_THRESHOLD         (I_THRESHOLD),
    .O_EDGE_PIXEL        (O_EDGE_PIXEL),
    .O_EDGE_COLUMN       (O_EDGE_COLUMN),
    .O_EDGE_ROW          (O_EDGE_ROW),
    .O_EDGE_VALID        (O_EDGE_VALID),
    .O_FRAME_DONE        (O_FRAME_DONE)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    bit valid;
    int magnitude;
    int column;
    int row;
  } entry_t;

  entry_t pipe[$];
  int     checks = 0;
  int     errors = 0;
  bit     reset_pending = 0;
  int     held_pixel = 0;
  int     held_column = 0;
  int     held_row = 0;

  task automatic check_value(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Neighbours in raster order: tl, t, tr, ml, mr, bl, b, br.
  function automatic int sobel_magnitude(input logic [63:0] m);
    int n[8];
    int gx, gy, sum;
    for (int i = 0; i < 8; i++) n[i] = int'(m[63-8*i -: 8]);
    gx  = (n[2] + 2*n[4] + n[7]) - (n[0] + 2*n[3] + n[5]);
    gy  = (n[5] + 2*n[6] + n[7]) - (n[0] + 2*n[1] + n[2]);
    sum = iabs(gx) + iabs(gy);
    return (sum > 255) ? 255 : sum;
  endfunction

  function automatic int output_pixel(input int magnitude, input int threshold);
`ifdef SOBEL_BINARY_THRESHOLD_EN
    return (magnitude >= threshold) ? 255 : 0;
`else
    return magnitude;
`endif
  endfunction

  task automatic check_outputs();
    entry_t e;
    bit exp_done;
    if (reset_pending) begin
      held_pixel = 0;
      held_column = 0;
      held_row = 0;
    end
    if (pipe.size() == 3) begin
      e = pipe.pop_front();
      if (reset_pending) e.valid = 0;
      if (e.valid) begin
        held_pixel  = output_pixel(e.magnitude, int'(I_THRESHOLD));
        held_column = e.column;
        held_row    = e.row;
      end
      exp_done = e.valid && (e.column == COLS - 2) && (e.row == ROWS - 2);
      check_value("valid",  int'(O_EDGE_VALID),  int'(e.valid));
      check_value("done",   int'(O_FRAME_DONE),  int'(exp_done));
      check_value("pixel",  int'(O_EDGE_PIXEL),  held_pixel);
      check_value("column", int'(O_EDGE_COLUMN), held_column);
      check_value("row",    int'(O_EDGE_ROW),    held_row);
    end
    reset_pending = 0;
  endtask

  task automatic drive(input bit rst, input bit rdy, input logic [63:0] m,
                       input int col, input int row, input int thr);
    entry_t e;
    I_RESET              = rst;
    I_PIXEL_MATRIX_READY = rdy;
    I_PIXEL_MATRIX       = m;
    I_PIXEL_COLUMN       = 10'(col);
    I_PIXEL_ROW          = 9'(row);
    I_THRESHOLD          = 8'(thr);
    e.valid     = rdy && !rst;
    e.magnitude = sobel_magnitude(m);
    e.column    = col + 1;
    e.row       = row + 1;
    if (rst) begin
      foreach (pipe[i]) pipe[i].valid = 0;
      reset_pending = 1;
    end
    pipe.push_back(e);
  endtask

  task automatic step(input bit rst, input bit rdy, input logic [63:0] m,
                      input int col, input int row, input int thr);
    @(negedge I_CLK);
    check_outputs();
    drive(rst, rdy, m, col, row, thr);
  endtask

  function automatic logic [63:0] random_matrix();
    logic [63:0] m;
    int mode;
    mode = int'($urandom_range(0, 3));
    for (int i = 0; i < 8; i++) begin
      case (mode)
        0:       m[8*i +: 8] = 8'($urandom_range(0, 255));
        1:       m[8*i +: 8] = $urandom_range(0, 1) ? 8'd255 : 8'd0;
        2:       m[8*i +: 8] = 8'($urandom_range(100, 110));
        default: m[8*i +: 8] = 8'($urandom_range(0, 20));
      endcase
    end
    return m;
  endfunction

  logic [63:0] flat_m, vedge_m, tr10_m;

  initial begin
    flat_m  = {8{8'd100}};
    vedge_m = {8'd0, 8'd128, 8'd255, 8'd0, 8'd255, 8'd0, 8'd128, 8'd255};
    tr10_m  = {8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    drive(1, 1, random_matrix(), 3, 3, 20);
    repeat (3) step(1, 1, random_matrix(), 3, 3, 20);

    step(0, 1, flat_m,  5,  7, 20);
    step(0, 1, vedge_m, 10, 20, 20);
    step(0, 1, tr10_m,  11, 21, 20);
    step(0, 0, random_matrix(), 0, 0, 20);
    step(0, 0, random_matrix(), 0, 0, 20);
    step(0, 1, tr10_m,  12, 22, 21);
    step(0, 0, random_matrix(), 0, 0, 21);
    step(0, 0, random_matrix(), 0, 0, 21);

    for (int i = 0; i < 5; i++) step(0, 1, random_matrix(), 100 + i, 200, 60);
    step(0, 0, random_matrix(), 1, 1, 60);
    step(0, 0, random_matrix(), 1, 1, 60);
    step(0, 1, random_matrix(), 106, 200, 60);
    repeat (4) step(0, 0, random_matrix(), 1, 1, 60);

    step(0, 1, random_matrix(), 300, 300, 60);
    step(0, 1, random_matrix(), 301, 300, 60);
    step(1, 1, random_matrix(), 302, 300, 60);
    repeat (4) step(0, 0, random_matrix(), 2, 2, 60);

    step(0, 1, random_matrix(), 637, 477, 60);
    step(0, 1, random_matrix(), 10, 10, 60);
    step(0, 1, random_matrix(), 637, 476, 60);
    step(0, 1, random_matrix(), 636, 477, 60);
    repeat (4) step(0, 0, random_matrix(), 3, 3, 60);

    for (int i = 0; i < 400; i++) begin
      bit rst, rdy;
      int col, row;
      rst = ($urandom_range(0, 59) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      col = int'($urandom_range(0, COLS - 3));
      row = int'($urandom_range(0, ROWS - 3));
      if ($urandom_range(0, 9) == 0) begin
        col = COLS - 3;
        row = ROWS - 3;
      end
      step(rst, rdy, random_matrix(), col, row, int'($urandom_range(0, 255)));
    end
    repeat (4) step(0, 0, random_matrix(), 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
